alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_ctrl_dec.sv | 78 +++++++
 rtl/alu_issue_stage.sv | 87 ++++++++
 tb/tb_alu_issue_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: opcodes, ALU control codes,
// elastic-buffer state encoding and the decoded-entry record.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b1000;
    localparam logic [3:0] ALU_SLL     = 4'b1001;
    localparam logic [3:0] ALU_SRA     = 4'b1010;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic            illegal;
    } dec_entry_t;

    function automatic logic signed [XLEN-1:0] sext12(input logic signed [11:0] imm);
        logic signed [XLEN-1:0] wide;
        wide = imm;
        return wide;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder producing the ALU control code and operands.
// Shift encodings are decoded only when ALU_ISSUE_SHIFT_EN is defined.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output dec_entry_t  entry
);

    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic [3:0]         ctrl;
    logic [31:0]        op2;
    logic               unused_rs1_field;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = sext12(instr[31:20]);
    assign imm_s  = sext12({instr[31:25], instr[11:7]});
    assign unused_rs1_field = ^instr[19:15];

    // Shared funct3 mapping for R-type and OP-IMM; SUB exists only for R-type.
    function automatic logic [3:0] arith_ctrl(input logic [2:0] fn3, input logic [6:0] fn7,
                                              input logic is_reg);
        logic [3:0] res;
        res = ALU_ILLEGAL;
        case (fn3)
            3'b000: begin
                if (!is_reg || fn7 == F7_BASE) res = ALU_ADD;
                else if (fn7 == F7_ALT)        res = ALU_SUB;
            end
            3'b111: res = ALU_AND;
            3'b110: res = ALU_OR;
            3'b010: res = ALU_SLT;
`ifdef ALU_ISSUE_SHIFT_EN
            3'b001: if (fn7 == F7_BASE) res = ALU_SLL;
            3'b101: if (fn7 == F7_ALT)  res = ALU_SRA;
`endif
            default: res = ALU_ILLEGAL;
        endcase
        return res;
    endfunction

    always_comb begin
        ctrl = ALU_ILLEGAL;
        op2  = rs2_val;
        case (opcode)
            OPC_RTYPE: ctrl = arith_ctrl(f3, f7, 1'b1);
            OPC_ITYPE: begin
                ctrl = arith_ctrl(f3, f7, 1'b0);
                op2  = imm_i;
            end
            OPC_LOAD: if (f3 == 3'b010) begin
                ctrl = ALU_ADD;
                op2  = imm_i;
            end
            OPC_STORE: if (f3 == 3'b010) begin
                ctrl = ALU_ADD;
                op2  = imm_s;
            end
            OPC_BRANCH: if (f3 == 3'b000) ctrl = ALU_SUB;
            default: ctrl = ALU_ILLEGAL;
        endcase
        // Unsupported encodings always present rs2 on operand 2.
        if (ctrl == ALU_ILLEGAL) op2 = rs2_val;
        entry.ctrl    = ctrl;
        entry.op1     = rs1_val;
        entry.op2     = op2;
        entry.illegal = (ctrl == ALU_ILLEGAL);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decoder at the input feeding a two-entry elastic
// ID/EX buffer (head + skid). Shift support is gated by ALU_ISSUE_SHIFT_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_in_1,
    output logic [31:0] alu_in_2,
    output logic        illegal
);

    dec_entry_t dec_p0;
    dec_entry_t main_p1;
    dec_entry_t skid_p1;
    buf_state_t state;
    logic       in_ready_q;
    logic       accept;
    logic       pop;

    alu_ctrl_dec u_dec (
        .instr   (in_instr),
        .rs1_val (in_rs1_val),
        .rs2_val (in_rs2_val),
        .entry   (dec_p0)
    );

    assign accept = in_valid & in_ready_q;
    assign pop    = (state != BUF_EMPTY) & out_ready;

    // ---- stage p0 (decode) -> p1 (head/skid registers) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            main_p1    <= '0;
            skid_p1    <= '0;
        end else if (flush) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) begin
                    main_p1 <= dec_p0;
                    state   <= BUF_ONE;
                end
                BUF_ONE: begin
                    if (accept && !pop) begin
                        skid_p1    <= dec_p0;
                        state      <= BUF_FULL;
                        in_ready_q <= 1'b0;
                    end else if (accept) begin
                        main_p1 <= dec_p0;
                    end else if (pop) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: if (pop) begin
                    main_p1    <= skid_p1;
                    state      <= BUF_ONE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state      <= BUF_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != BUF_EMPTY);
    assign alu_ctrl  = main_p1.ctrl;
    assign alu_in_1  = main_p1.op1;
    assign alu_in_2  = main_p1.op2;
    assign illegal   = main_p1.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// buffer/flush/reset sequences, and randomized traffic against a queue model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, illegal;
    logic [31:0] in_instr, in_rs1_val, in_rs2_val;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in_1, alu_in_2;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef ALU_ISSUE_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    alu_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: instruction -> mnemonic -> ALU code / operand source.
    function automatic string mnem(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        if (op == 7'h33) begin
            if (f3 == 0 && f7 == 0)               return "add";
            if (f3 == 0 && f7 == 7'h20)           return "sub";
            if (f3 == 7)                          return "and";
            if (f3 == 6)                          return "or";
            if (f3 == 2)                          return "slt";
            if (SHIFT_EN && f3 == 1 && f7 == 0)   return "sll";
            if (SHIFT_EN && f3 == 5 && f7 == 7'h20) return "sra";
        end else if (op == 7'h13) begin
            if (f3 == 0)                          return "addi";
            if (f3 == 7)                          return "andi";
            if (f3 == 6)                          return "ori";
            if (f3 == 2)                          return "slti";
            if (SHIFT_EN && f3 == 1 && f7 == 0)   return "slli";
            if (SHIFT_EN && f3 == 5 && f7 == 7'h20) return "srai";
        end else if (op == 7'h03 && f3 == 2) return "lw";
        else if (op == 7'h23 && f3 == 2) return "sw";
        else if (op == 7'h63 && f3 == 0) return "beq";
        return "ill";
    endfunction

    task automatic ref_dec(input logic [31:0] i, input logic [31:0] rs2,
                           output logic [3:0] c, output logic [31:0] o2, output logic ill);
        string m;
        int    imm_i, imm_s;
        imm_i = $signed(i[31:20]);
        imm_s = $signed({i[31:25], i[11:7]});
        m   = mnem(i);
        ill = 1'b0;
        o2  = rs2;
        case (m)
            "add", "lw", "sw", "addi": c = 4'd2;
            "sub", "beq":              c = 4'd6;
            "and", "andi":             c = 4'd0;
            "or", "ori":               c = 4'd1;
            "slt", "slti":             c = 4'd8;
            "sll", "slli":             c = 4'd9;
            "sra", "srai":             c = 4'd10;
            default: begin c = 4'd15; ill = 1'b1; end
        endcase
        if (m == "sw") o2 = imm_s;
        else if (m == "lw" || (i[6:0] == 7'h13 && !ill)) o2 = imm_i;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] op2;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        ill;
    } ent_t;

    vec_t vecs[14];
    ent_t q[$];

    initial begin
        vecs[0]  = '{"add",  32'h002081B3, 32'd5,  32'd7,  4'b0010, 32'd7,        1'b0};
        vecs[1]  = '{"addi", 32'hFFF08093, 32'd3,  32'd9,  4'b0010, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{"sw",   32'h00112423, 32'd100,32'd4,  4'b0010, 32'd8,        1'b0};
        vecs[3]  = '{"beq",  32'h00208463, 32'd6,  32'd6,  4'b0110, 32'd6,        1'b0};
        vecs[4]  = '{"jal",  32'h0000006F, 32'd1,  32'h55, 4'b1111, 32'h55,       1'b1};
        vecs[5]  = '{"sub",  32'h40208033, 32'd9,  32'd4,  4'b0110, 32'd4,        1'b0};
        vecs[6]  = '{"and",  32'h0020F033, 32'hF0, 32'h3C, 4'b0000, 32'h3C,       1'b0};
        vecs[7]  = '{"or",   32'h0020E033, 32'hA,  32'h5,  4'b0001, 32'h5,        1'b0};
        vecs[8]  = '{"slt",  32'h0020A033, 32'd2,  32'd3,  4'b1000, 32'd3,        1'b0};
        vecs[9]  = '{"lw",   32'hFFC0A083, 32'h40, 32'd1,  4'b0010, 32'hFFFFFFFC, 1'b0};
        vecs[10] = '{"lb",   32'h00008083, 32'd1,  32'h77, 4'b1111, 32'h77,       1'b1};
        vecs[11] = '{"xori", 32'h00F0C093, 32'd1,  32'h66, 4'b1111, 32'h66,       1'b1};
`ifdef ALU_ISSUE_SHIFT_EN
        vecs[12] = '{"srai", 32'h4030D093, 32'd8,  32'h11, 4'b1010, 32'h403,      1'b0};
        vecs[13] = '{"sll",  32'h00209033, 32'd8,  32'h12, 4'b1001, 32'h12,       1'b0};
`else
        vecs[12] = '{"srai", 32'h4030D093, 32'd8,  32'h11, 4'b1111, 32'h11,       1'b1};
        vecs[13] = '{"sll",  32'h00209033, 32'd8,  32'h12, 4'b1111, 32'h12,       1'b1};
`endif

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_alu_ctrl",  alu_ctrl,  0);
        chk("rst_alu_in_1",  alu_in_1,  0);
        chk("rst_alu_in_2",  alu_in_2,  0);
        chk("rst_illegal",   illegal,   0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors, one per cycle at full throughput.
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            in_valid = 1'b1;
            in_instr = vecs[k].instr; in_rs1_val = vecs[k].rs1; in_rs2_val = vecs[k].rs2;
            tick();
            chk({vecs[k].name, "_valid"}, out_valid, 1);
            chk({vecs[k].name, "_ctrl"},  alu_ctrl,  vecs[k].ctrl);
            chk({vecs[k].name, "_in1"},   alu_in_1,  vecs[k].rs1);
            chk({vecs[k].name, "_in2"},   alu_in_2,  vecs[k].op2);
            chk({vecs[k].name, "_ill"},   illegal,   vecs[k].ill);
            chk({vecs[k].name, "_ready"}, in_ready,  1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_empty", out_valid, 0);

        // Backpressure: A, B absorbed, C held off, then in-order drain.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h002081B3; in_rs1_val = 32'd11; in_rs2_val = 32'd1;
        tick();
        chk("bp_one_ready", in_ready, 1);
        in_instr = 32'h40208033; in_rs1_val = 32'd22;
        tick();
        chk("bp_full_ready", in_ready, 0);
        in_instr = 32'h0020F033; in_rs1_val = 32'd33;
        tick();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_in1",   alu_in_1, 11);
        chk("bp_hold_ctrl",  alu_ctrl, 4'b0010);
        out_ready = 1'b1;
        tick();
        chk("bp_pop_b_in1",  alu_in_1, 22);
        chk("bp_pop_b_ctrl", alu_ctrl, 4'b0110);
        chk("bp_pop_b_rdy",  in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_pop_c_in1",  alu_in_1, 33);
        chk("bp_pop_c_ctrl", alu_ctrl, 4'b0000);
        tick();
        chk("bp_empty", out_valid, 0);

        // Flush while FULL with an instruction offered.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h002081B3; in_rs1_val = 32'd1;
        tick();
        in_rs1_val = 32'd2;
        tick();
        chk("fl_full_ready", in_ready, 0);
        in_rs1_val = 32'd3; flush = 1'b1;
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready,  1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_no_emit", out_valid, 0);

        // Flush in ONE discards the concurrently accepted instruction.
        in_valid = 1'b1; in_rs1_val = 32'd4;
        tick();
        in_rs1_val = 32'd5; flush = 1'b1;
        tick();
        chk("fl1_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl1_no_emit", out_valid, 0);

        // Asynchronous reset mid-operation.
        out_ready = 1'b0; in_valid = 1'b1; in_rs1_val = 32'd6;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready,  1);
        chk("ar_ctrl",  alu_ctrl,  0);
        chk("ar_in1",   alu_in_1,  0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("ar_post_valid", out_valid, 0);

        // Randomized traffic against a queue model.
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] ins;
            logic [6:0]  ops[7];
            logic [6:0]  f7s[3];
            logic        acc, pp;
            ent_t        e;
            chk("rnd_out_valid", out_valid, (q.size() > 0));
            chk("rnd_in_ready",  in_ready,  (q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_ctrl", alu_ctrl, q[0].ctrl);
                chk("rnd_in1",  alu_in_1, q[0].op1);
                chk("rnd_in2",  alu_in_2, q[0].op2);
                chk("rnd_ill",  illegal,  q[0].ill);
            end
            ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h00};
            ops[6] = 7'($urandom);
            f7s = '{7'h00, 7'h20, 7'h00};
            f7s[2] = 7'($urandom);
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 6)];
            ins[31:25] = f7s[$urandom_range(0, 2)];
            in_instr   = ins;
            in_rs1_val = $urandom;
            in_rs2_val = $urandom;
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            acc = in_valid && (q.size() < 2);
            pp  = out_ready && (q.size() > 0);
            ref_dec(ins, in_rs2_val, e.ctrl, e.op2, e.ill);
            e.op1 = in_rs1_val;
            tick();
            if (flush) q.delete();
            else begin
                if (pp)  void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
